// File: rtl/cat_trap_game_fsm_if.sv
// Cat Trap game sequencer bus.
// master: button source (debouncer side), reads board/status.
// slave : game sequencer, drives board/status, receives button pulses.
//   BtnC/U/D/L/R  one-cycle debounced pulses
//   state         3-bit game state code
//   blocked       64-bit board bitmap, bit = row*8+col
//   cat_*/cur_*   cat and cursor coordinates
//   move_count    valid placements this game (saturating)
//   busy          high while the cat is choosing its move
interface cat_trap_game_fsm_if;
  logic        BtnC, BtnU, BtnD, BtnL, BtnR;
  logic [2:0]  state;
  logic [63:0] blocked;
  logic [2:0]  cat_row, cat_col;
  logic [2:0]  cur_row, cur_col;
  logic [7:0]  move_count;
  logic        busy;

  modport master (
    output BtnC, BtnU, BtnD, BtnL, BtnR,
    input  state, blocked, cat_row, cat_col, cur_row, cur_col, move_count, busy
  );
  modport slave (
    input  BtnC, BtnU, BtnD, BtnL, BtnR,
    output state, blocked, cat_row, cat_col, cur_row, cur_col, move_count, busy
  );
endinterface

// File: rtl/cat_trap_game_fsm.sv
// Cat Trap game sequencer: owns the 8x8 board (blocked cells, cat, cursor,
// move count) and the START/PLAY/CATMOVE/GAMEOVER/GAMEWIN state machine.
// Ports:
//   clk    system clock, posedge
//   reset  synchronous active-high
//   bus    slave side of cat_trap_game_fsm_if (buttons in, board/status out)
module cat_trap_game_fsm #(
  parameter logic [63:0] INIT_BLOCKS = 64'h0,
  parameter logic [2:0]  CAT_ROW0    = 3'd3,
  parameter logic [2:0]  CAT_COL0    = 3'd3
) (
  input  logic                 clk,
  input  logic                 reset,
  cat_trap_game_fsm_if.slave   bus
);

  typedef enum logic [2:0] {
    S_START   = 3'b001,
    S_PLAY    = 3'b010,
    S_CATMOVE = 3'b011,
    S_OVER    = 3'b100,
    S_WIN     = 3'b101
  } state_t;

  state_t      r_state;
  logic [63:0] r_blocked;
  logic [2:0]  r_cat_row, r_cat_col, r_cur_row, r_cur_col;
  logic [7:0]  r_move_count;
  logic        r_busy;
  // cat move scan: neighbour index and best-so-far
  logic [1:0]  r_k;
  logic        r_found;
  logic [2:0]  r_best_row, r_best_col, r_best_d;

  logic [2:0]  w_nb_row, w_nb_col, w_nb_d;
  logic        w_nb_free, w_take, w_found;
  logic [2:0]  w_best_row, w_best_col, w_best_d;
  logic [5:0]  w_cur_idx;
  logic        w_place_ok, w_reinit;

  function automatic logic [2:0] edist(input logic [2:0] r, input logic [2:0] c);
    logic [2:0] a, b;
    a = (r < (3'd7 - r)) ? r : (3'd7 - r);
    b = (c < (3'd7 - c)) ? c : (3'd7 - c);
    return (a < b) ? a : b;
  endfunction

  // Neighbour under test this cycle; the cat is never on an edge here,
  // so the +/-1 never wraps.
  always_comb begin
    w_nb_row = r_cat_row;
    w_nb_col = r_cat_col;
    case (r_k)
      2'd0:    w_nb_row = r_cat_row - 3'd1;
      2'd1:    w_nb_row = r_cat_row + 3'd1;
      2'd2:    w_nb_col = r_cat_col - 3'd1;
      default: w_nb_col = r_cat_col + 3'd1;
    endcase
    w_nb_free  = ~r_blocked[{w_nb_row, w_nb_col}];
    w_nb_d     = edist(w_nb_row, w_nb_col);
    // strict less-than keeps the earlier neighbour on ties
    w_take     = w_nb_free && (!r_found || (w_nb_d < r_best_d));
    w_best_row = w_take ? w_nb_row : r_best_row;
    w_best_col = w_take ? w_nb_col : r_best_col;
    w_best_d   = w_take ? w_nb_d   : r_best_d;
    w_found    = r_found | w_nb_free;
  end

  assign w_cur_idx  = {r_cur_row, r_cur_col};
  assign w_place_ok = ~r_blocked[w_cur_idx] &&
                      !((r_cur_row == r_cat_row) && (r_cur_col == r_cat_col));
  // reset and restart from an end state share the same board load
  assign w_reinit   = reset ||
                      (((r_state == S_OVER) || (r_state == S_WIN)) && bus.BtnC);

  always_ff @(posedge clk) begin
    if (w_reinit) begin
      r_state      <= S_START;
      r_blocked    <= INIT_BLOCKS;
      r_cat_row    <= CAT_ROW0;
      r_cat_col    <= CAT_COL0;
      r_cur_row    <= 3'd0;
      r_cur_col    <= 3'd0;
      r_move_count <= 8'd0;
      r_busy       <= 1'b0;
      r_k          <= 2'd0;
      r_found      <= 1'b0;
      r_best_row   <= 3'd0;
      r_best_col   <= 3'd0;
      r_best_d     <= 3'd0;
    end else begin
      case (r_state)
        S_START: if (bus.BtnC) r_state <= S_PLAY;
        S_PLAY: begin
          if (bus.BtnC) begin
            if (w_place_ok) begin
              r_blocked[w_cur_idx] <= 1'b1;
              if (r_move_count != 8'hFF) r_move_count <= r_move_count + 8'd1;
              r_state <= S_CATMOVE;
              r_busy  <= 1'b1;
              r_k     <= 2'd0;
              r_found <= 1'b0;
            end
          end else if (bus.BtnU) begin
            if (r_cur_row != 3'd0) r_cur_row <= r_cur_row - 3'd1;
          end else if (bus.BtnD) begin
            if (r_cur_row != 3'd7) r_cur_row <= r_cur_row + 3'd1;
          end else if (bus.BtnL) begin
            if (r_cur_col != 3'd0) r_cur_col <= r_cur_col - 3'd1;
          end else if (bus.BtnR) begin
            if (r_cur_col != 3'd7) r_cur_col <= r_cur_col + 3'd1;
          end
        end
        S_CATMOVE: begin
          r_k        <= r_k + 2'd1;
          r_found    <= w_found;
          r_best_row <= w_best_row;
          r_best_col <= w_best_col;
          r_best_d   <= w_best_d;
          if (r_k == 2'd3) begin
            r_busy <= 1'b0;
            if (!w_found) begin
              r_state <= S_WIN;
            end else begin
              r_cat_row <= w_best_row;
              r_cat_col <= w_best_col;
              if ((w_best_row == 3'd0) || (w_best_row == 3'd7) ||
                  (w_best_col == 3'd0) || (w_best_col == 3'd7))
                r_state <= S_OVER;
              else
                r_state <= S_PLAY;
            end
          end
        end
        default: ;  // end states frozen until BtnC (handled by w_reinit)
      endcase
    end
  end

  assign bus.state      = r_state;
  assign bus.blocked    = r_blocked;
  assign bus.cat_row    = r_cat_row;
  assign bus.cat_col    = r_cat_col;
  assign bus.cur_row    = r_cur_row;
  assign bus.cur_col    = r_cur_col;
  assign bus.move_count = r_move_count;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_cat_trap_game_fsm.sv
// Directed bench for cat_trap_game_fsm: default board (escape, cursor,
// invalid placements, restart, mid-move reset) and a trap board (GAMEWIN).
module tb_cat_trap_game_fsm;
  localparam logic [63:0] TRAP = (64'd1 << 19) | (64'd1 << 35) | (64'd1 << 26) | (64'd1 << 28);
  localparam logic [4:0] BC = 5'b10000, BU = 5'b01000, BD = 5'b00100,
                         BL = 5'b00010, BR = 5'b00001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  cat_trap_game_fsm_if ifa ();
  cat_trap_game_fsm_if ifb ();

  cat_trap_game_fsm dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  cat_trap_game_fsm #(.INIT_BLOCKS(TRAP)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic [4:0] m);
    {ifa.BtnC, ifa.BtnU, ifa.BtnD, ifa.BtnL, ifa.BtnR} = m;
  endtask

  task automatic drive_b(input logic [4:0] m);
    {ifb.BtnC, ifb.BtnU, ifb.BtnD, ifb.BtnL, ifb.BtnR} = m;
  endtask

  // one-cycle pulse; returns at the negedge after the consuming posedge
  task automatic pa(input logic [4:0] m);
    @(negedge clk); drive_a(m);
    @(negedge clk); drive_a(5'b0);
  endtask

  task automatic pb(input logic [4:0] m);
    @(negedge clk); drive_b(m);
    @(negedge clk); drive_b(5'b0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // place at cursor on DUT A; checks busy for 4 cycles, ends when cat moved
  task automatic place_a(input string tag);
    pa(BC);
    chk({tag, "_st_cm"}, 64'(ifa.state), 64'(3'b011));
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 64'(ifa.busy), 64'd1);
      tick(1);
    end
    chk({tag, "_busy0"}, 64'(ifa.busy), 64'd0);
  endtask

  initial begin
    drive_a(5'b0);
    drive_b(5'b0);
    tick(2);
    reset = 1'b0;
    chk("rst_state", 64'(ifa.state), 64'(3'b001));
    chk("rst_cat",   64'({ifa.cat_row, ifa.cat_col}), 64'({3'd3, 3'd3}));
    chk("rst_cur",   64'({ifa.cur_row, ifa.cur_col}), 64'd0);
    chk("rst_blk",   ifa.blocked, 64'd0);
    chk("rst_cnt",   64'(ifa.move_count), 64'd0);
    chk("rst_busy",  64'(ifa.busy), 64'd0);

    pa(BD);
    chk("start_dir_ign", 64'({ifa.cur_row, ifa.cur_col}), 64'd0);
    pa(BC);
    chk("start_play", 64'(ifa.state), 64'(3'b010));
    pa(BU);
    chk("cur_sat_up", 64'({ifa.cur_row, ifa.cur_col}), 64'd0);

    // escape move 1 at (0,0); buttons pressed mid-move are ignored
    pa(BC);
    chk("p1_st", 64'(ifa.state), 64'(3'b011));
    chk("p1_blk", ifa.blocked, 64'd1);
    chk("p1_cnt", 64'(ifa.move_count), 64'd1);
    drive_a(BD | BR); tick(1);
    drive_a(BC); tick(1);
    drive_a(5'b0); tick(2);
    chk("p1_busy0", 64'(ifa.busy), 64'd0);
    chk("p1_cat", 64'({ifa.cat_row, ifa.cat_col}), 64'({3'd2, 3'd3}));
    chk("p1_play", 64'(ifa.state), 64'(3'b010));
    chk("cm_btn_cur", 64'({ifa.cur_row, ifa.cur_col}), 64'd0);
    chk("cm_btn_blk", ifa.blocked, 64'd1);

    // invalid: already blocked
    pa(BC);
    chk("inv_blk_st", 64'(ifa.state), 64'(3'b010));
    chk("inv_blk_cnt", 64'(ifa.move_count), 64'd1);

    pa(BD); pa(BD); pa(BR);
    chk("cur_21", 64'({ifa.cur_row, ifa.cur_col}), 64'({3'd2, 3'd1}));
    pa(BU | BL);
    chk("cur_prio", 64'({ifa.cur_row, ifa.cur_col}), 64'({3'd1, 3'd1}));
    pa(BD); pa(BR); pa(BR);
    chk("cur_cat", 64'({ifa.cur_row, ifa.cur_col}), 64'({3'd2, 3'd3}));
    pa(BC);
    chk("inv_cat_st", 64'(ifa.state), 64'(3'b010));
    chk("inv_cat_cnt", 64'(ifa.move_count), 64'd1);
    chk("inv_cat_blk", ifa.blocked, 64'd1);

    // BtnC with a direction: placement wins, cursor holds; cell (2,2)
    pa(BL);
    pa(BC | BD);
    chk("cprio_cur", 64'({ifa.cur_row, ifa.cur_col}), 64'({3'd2, 3'd2}));
    chk("cprio_st", 64'(ifa.state), 64'(3'b011));
    tick(4);
    // cat (2,3): up (1,3) d=1 free -> wins
    chk("cprio_cat", 64'({ifa.cat_row, ifa.cat_col}), 64'({3'd1, 3'd3}));
    chk("cprio_play", 64'(ifa.state), 64'(3'b010));

    // cat (1,3): up (0,3) free, d=0 -> GAMEOVER, count 3
    repeat (6) pa(BD);
    pa(BR);
    chk("cur_sat_dn", 64'({ifa.cur_row, ifa.cur_col}), 64'({3'd7, 3'd3}));
    pa(BD);
    chk("cur_sat_dn2", 64'({ifa.cur_row, ifa.cur_col}), 64'({3'd7, 3'd3}));
    place_a("p3");
    chk("p3_cat", 64'({ifa.cat_row, ifa.cat_col}), 64'({3'd0, 3'd3}));
    chk("p3_over", 64'(ifa.state), 64'(3'b100));
    chk("p3_cnt", 64'(ifa.move_count), 64'd3);
    chk("p3_blk", ifa.blocked, (64'd1 << 59) | (64'd1 << 18) | 64'd1);

    pa(BU);
    chk("over_frozen", 64'({ifa.cur_row, ifa.cur_col}), 64'({3'd7, 3'd3}));
    pa(BC);
    chk("rs_state", 64'(ifa.state), 64'(3'b001));
    chk("rs_blk", ifa.blocked, 64'd0);
    chk("rs_cat", 64'({ifa.cat_row, ifa.cat_col}), 64'({3'd3, 3'd3}));
    chk("rs_cnt", 64'(ifa.move_count), 64'd0);
    chk("rs_cur", 64'({ifa.cur_row, ifa.cur_col}), 64'd0);

    // reset on 2nd CATMOVE cycle
    pa(BC);
    pa(BC);
    chk("mr_cm", 64'(ifa.state), 64'(3'b011));
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("mr_state", 64'(ifa.state), 64'(3'b001));
    chk("mr_cat", 64'({ifa.cat_row, ifa.cat_col}), 64'({3'd3, 3'd3}));
    chk("mr_blk", ifa.blocked, 64'd0);
    chk("mr_busy", 64'(ifa.busy), 64'd0);
    chk("mr_cnt", 64'(ifa.move_count), 64'd0);
    reset = 1'b0;
    tick(5);
    chk("mr_hold", 64'({ifa.cat_row, ifa.cat_col}), 64'({3'd3, 3'd3}));

    // trap board: all four neighbours blocked -> GAMEWIN, cat stays
    chk("tr_init", ifb.blocked, TRAP);
    pb(BC);
    pb(BC);
    chk("tr_cm", 64'(ifb.state), 64'(3'b011));
    tick(3);
    chk("tr_busy", 64'(ifb.busy), 64'd1);
    tick(1);
    chk("tr_win", 64'(ifb.state), 64'(3'b101));
    chk("tr_cat", 64'({ifb.cat_row, ifb.cat_col}), 64'({3'd3, 3'd3}));
    chk("tr_busy0", 64'(ifb.busy), 64'd0);
    pb(BC);
    chk("tr_rs_st", 64'(ifb.state), 64'(3'b001));
    chk("tr_rs_blk", ifb.blocked, TRAP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cat_trap_game_fsm.md
# cat_trap_game_fsm

Game sequencer for the Cat Trap VGA game. It owns the 8x8 board state: blocked cells, cat position, player cursor and move count. It also runs the START/PLAY/cat-move/GAMEOVER/GAMEWIN state machine. Its outputs feed the display controller, which only paints what this block reports. Button inputs come from the debouncer as single-cycle pulses.

## Interface
- INIT_BLOCKS, 64'h0: board loaded at reset and on every return to START; bit index = row*8+col.
- CAT_ROW0, 3'd3: cat start row.
- CAT_COL0, 3'd3: cat start column.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- BtnC  in  1  debounced one-cycle pulse: start / place block / restart.
- BtnU, BtnD, BtnL, BtnR  in  1 each  debounced one-cycle pulses: cursor moves.
- state  out  3  START=3'b001, PLAY=3'b010, CATMOVE=3'b011, GAMEOVER=3'b100, GAMEWIN=3'b101.
- blocked  out  64  board bitmap; 1 = blocked cell.
- cat_row, cat_col  out  3 each  cat position.
- cur_row, cur_col  out  3 each  cursor position.
- move_count  out  8  valid placements this game; saturates at 255.
- busy  out  1  high while in CATMOVE.

## Operation
- Reset and START entry (re)initialise the game:
  - blocked=INIT_BLOCKS, cat=(CAT_ROW0,CAT_COL0), cursor=(0,0), move_count=0.
  - Reset also sets state=START and busy=0.
- START: BtnC -> PLAY. Direction buttons are ignored.
- PLAY:
  - Cursor: BtnU: row-1. BtnD: row+1. BtnL: col-1. BtnR: col+1.
  - Cursor saturates at 0 and 7; it never wraps.
  - If several direction pulses arrive together, only the highest priority applies: U > D > L > R.
  - BtnC places a block at the cursor when that cell is not blocked and is not the cat cell. On a valid placement: set the blocked bit, increment move_count (saturating), go to CATMOVE.
  - An invalid BtnC (cell already blocked, or the cat cell) is ignored: no state change, no count change.
  - BtnC has priority over a simultaneous direction pulse; the cursor does not move that cycle.
- CATMOVE: exactly 4 cycles, scan counter k=0..3, one neighbour per cycle.
  - k=0 up (r-1,c), k=1 down (r+1,c), k=2 left (r,c-1), k=3 right (r,c+1).
  - Edge distance d(r,c) = min(r, 7-r, c, 7-c), 3 bits.
  - A free neighbour replaces the current best only if its d is strictly less. Ties keep the earlier k.
  - Neighbours are always in range, because the cat is never on an edge while in CATMOVE.
  - On the clock edge after k=3:
    - No free neighbour -> GAMEWIN; cat does not move.
    - Otherwise cat moves to the best neighbour. If the new position is on an edge (row or col 0 or 7) -> GAMEOVER, else -> PLAY.
  - All buttons are ignored in CATMOVE.
- GAMEOVER / GAMEWIN: outputs are frozen. BtnC -> START, with reinitialisation on the same edge.
- Reset in any state, including mid-CATMOVE, aborts to the reset values; no partial cat move is committed.

## Timing
- All outputs are registered and update on the posedge after the triggering pulse.
- START->PLAY: 1 cycle after BtnC.
- Valid placement:
  - blocked bit and move_count update, and state=CATMOVE, 1 cycle after BtnC.
  - Cat position and the next state update 4 cycles later, i.e. 5 cycles after BtnC.
- busy is high for exactly 4 cycles per valid placement.
- Cursor moves 1 cycle after the pulse.
- Reset is sampled on clk; outputs hold their reset values during the cycle after reset is asserted.

## Test plan
- Reset: state=001, cat=(3,3), cursor=(0,0), blocked=0, move_count=0, busy=0.
- START, then BtnC -> state=010 next cycle. Cursor checks:
  - BtnU at (0,0) -> cursor stays (0,0).
  - BtnD, BtnD, BtnR -> cursor (2,1).
  - BtnU and BtnL in the same cycle -> only the row changes.
- Escape sequence from the default board:
  - Place at (0,0): busy for 4 cycles, then cat=(2,3). Up (d=2) ties with left and beats down/right (d=3).
  - Place at (7,7): cat=(1,3).
  - Place at (7,6): cat=(0,3), state=100, move_count=3.
- Trap: INIT_BLOCKS with bits (2,3),(4,3),(3,2),(3,4) = bits 19, 35, 26, 28 set. Place at (0,0) -> after 4 CATMOVE cycles state=101, cat stays (3,3).
- Invalid BtnC in PLAY:
  - On blocked cell (0,0) -> state stays 010, move_count unchanged.
  - On cat cell (3,3) -> ignored.
  - Any button pulse during CATMOVE -> no effect.
- From GAMEOVER, BtnC -> state=001, blocked=INIT_BLOCKS, cat=(3,3), move_count=0.
- Assert reset on the 2nd CATMOVE cycle -> reset values next cycle; cat does not move.
